hdub_core_logic_gate_arbiter: RTL and testbench



---
 rtl/hdub_core_logic_gate_pkg.sv | 35 +++
 rtl/hdub_core_logic_rr_arbiter.sv | 54 +++++
 rtl/hdub_core_logic_gate_arbiter.sv | 107 ++++++++++
 tb/tb_hdub_core_logic_gate_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdub_core_logic_gate_pkg.sv
// Shared gate definitions for the logic unit and its clients.
// Holds the gate encoding, output-stage states and bitwise gate semantics.
package hdub_core_logic_gate;

   typedef enum logic [1:0] {
      GATE_AND = 2'd0,
      GATE_OR  = 2'd1,
      GATE_XOR = 2'd2,
      GATE_NOT = 2'd3
   } gate_type_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_e;

   // One bit of a gate; callers apply it per bit so any width shares it.
   function automatic logic gate_eval(
      input gate_type_e op,
      input logic       lhs,
      input logic       rhs
   );
      logic r;
      r = 1'b0;
      unique case (op)
         GATE_AND: r = lhs & rhs;
         GATE_OR:  r = lhs | rhs;
         GATE_XOR: r = lhs ^ rhs;
         GATE_NOT: r = ~lhs;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hdub_core_logic_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// The pointer moves past the winner only when the grant is taken.
module hdub_core_logic_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   import hdub_core_logic_gate::*;

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          found;
   int            gnt_idx;
   int            idx;

   // Cyclic search from the pointer for the first active request.
   always_comb begin
      grant   = '0;
      found   = 1'b0;
      gnt_idx = 0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt_idx      = idx;
            grant[idx]   = 1'b1;
         end
      end
   end

   // Pointer moves to the slot after the winner on a transfer.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         if (gnt_idx == N - 1) ptr_d = '0;
         else                  ptr_d = PW'(gnt_idx + 1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/hdub_core_logic_gate_arbiter.sv
// Time-multiplexed bitwise gate unit shared by several requesters.
// Round-robin pick, one-cycle evaluate, single-entry output register.
module hdub_core_logic_gate_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0][1:0]           req_op,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_lhs,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_rhs,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
   output logic [WIDTH-1:0]                  rsp_result,
   output logic [CNT_W-1:0]                  ops_done
);
   import hdub_core_logic_gate::*;

   localparam int IDW = $clog2(NUM_REQ);

   stage_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] grant;
   logic               can_accept;
   logic               xfer;
   logic               drain;
   logic [IDW-1:0]     win_idx;
   gate_type_e         win_op;
   logic [WIDTH-1:0]   win_lhs;
   logic [WIDTH-1:0]   win_rhs;
   logic [WIDTH-1:0]   win_res;

   hdub_core_logic_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (xfer),
      .grant   (grant)
   );

   assign rsp_valid  = (state_q == ST_FULL);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign ops_done   = cnt_q;

   // Handshake qualification and winner operand select.
   always_comb begin
      can_accept = !rsp_valid || rsp_ready;
      req_ready  = grant & {NUM_REQ{can_accept}};
      xfer       = |(req_ready & req_valid);
      drain      = rsp_valid && rsp_ready;
      win_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) win_idx = IDW'(i);
      end
      win_op  = gate_type_e'(req_op[win_idx]);
      win_lhs = req_lhs[win_idx];
      win_rhs = req_rhs[win_idx];
      win_res = '0;
      for (int b = 0; b < WIDTH; b++) begin
         win_res[b] = gate_eval(win_op, win_lhs[b], win_rhs[b]);
      end
   end

   // Output stage next state, result load and saturating counter.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_EMPTY: if (xfer)                state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !xfer)  state_d = ST_EMPTY;
         default:                           state_d = ST_EMPTY;
      endcase
      if (xfer) begin
         result_d = win_res;
         id_d     = win_idx;
      end
      if (drain && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // Output stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         result_q <= '0;
         id_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hdub_core_logic_gate_arbiter.sv
// Bench for the shared gate arbiter: reference model plus scoreboard.
// Second instance with a 4-bit counter exercises saturation.
module tb_hdub_core_logic_gate_arbiter;

   typedef struct {
      logic [1:0] id;
      logic [7:0] res;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] lhs;
      logic [7:0] rhs;
      logic [7:0] exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      req_valid = '0;
   logic [3:0]      req_ready;
   logic [3:0][1:0] req_op = '0;
   logic [3:0][7:0] req_lhs = '0;
   logic [3:0][7:0] req_rhs = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [1:0]      rsp_id;
   logic [7:0]      rsp_result;
   logic [15:0]     ops_done;

   logic [3:0]      v4 = '0;
   logic [3:0]      rdy4;
   logic [3:0][1:0] op4 = '0;
   logic [3:0][7:0] lhs4 = '0;
   logic [3:0][7:0] rhs4 = '0;
   logic            val4;
   logic [1:0]      id4;
   logic [7:0]      res4;
   logic [3:0]      ops4;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   logic m_full = 1'b0;
   int   m_ptr = 0;
   int   m_cnt = 0;
   vec_t tv[6];

   always #5 clk = ~clk;

   hdub_core_logic_gate_arbiter #(
      .NUM_REQ(4), .WIDTH(8), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_lhs(req_lhs), .req_rhs(req_rhs),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result),
      .ops_done(ops_done)
   );

   hdub_core_logic_gate_arbiter #(
      .NUM_REQ(4), .WIDTH(8), .CNT_W(4)
   ) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v4), .req_ready(rdy4),
      .req_op(op4), .req_lhs(lhs4), .req_rhs(rhs4),
      .rsp_valid(val4), .rsp_ready(1'b1),
      .rsp_id(id4), .rsp_result(res4),
      .ops_done(ops4)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_gate(input logic [1:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   function automatic int ref_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // One clock: check request side at negedge, update model, check after edge.
   task automatic cycle();
      int   w;
      logic acc;
      logic [3:0] exp_rdy;
      exp_t e;
      @(negedge clk);
      w   = ref_pick(req_valid, m_ptr);
      acc = (!m_full || rsp_ready) && (w >= 0);
      exp_rdy = '0;
      if (acc) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_full && rsp_ready) begin
         void'(q.pop_front());
         if (m_cnt < 16'hFFFF) m_cnt++;
      end
      if (acc) begin
         e.id  = 2'(w);
         e.res = ref_gate(req_op[w], req_lhs[w], req_rhs[w]);
         q.push_back(e);
         m_ptr = (w + 1) % 4;
      end
      m_full = acc || (m_full && !rsp_ready);
      @(posedge clk);
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full && q.size() > 0) begin
         chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
         chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
      end
      chk("ops_done", 32'(ops_done), 32'(m_cnt));
   endtask

   initial begin
      logic [1:0] rot[5];
      tv[0] = '{2'd0, 8'hF0, 8'h3C, 8'h30};
      tv[1] = '{2'd3, 8'hA5, 8'hFF, 8'h5A};
      tv[2] = '{2'd1, 8'h0F, 8'h30, 8'h3F};
      tv[3] = '{2'd2, 8'hFF, 8'h0F, 8'hF0};
      tv[4] = '{2'd0, 8'hAA, 8'h55, 8'h00};
      tv[5] = '{2'd1, 8'hAA, 8'h55, 8'hFF};
      rot[0] = 2'd0; rot[1] = 2'd1; rot[2] = 2'd2;
      rot[3] = 2'd3; rot[4] = 2'd0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_result", 32'(rsp_result), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_ops", 32'(ops_done), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single AND on requester 2.
      req_valid  = 4'b0100;
      req_op[2]  = 2'd0;
      req_lhs[2] = 8'hF0;
      req_rhs[2] = 8'h3C;
      rsp_ready  = 1'b1;
      cycle();
      chk("and_res", 32'(rsp_result), 32'h30);
      chk("and_id", 32'(rsp_id), 32'd2);
      req_valid = '0;
      cycle();
      chk("and_ops", 32'(ops_done), 32'd1);

      // Gate vector table.
      for (int i = 0; i < 6; i++) begin
         req_valid      = '0;
         req_valid[i%4] = 1'b1;
         req_op[i%4]    = tv[i].op;
         req_lhs[i%4]   = tv[i].lhs;
         req_rhs[i%4]   = tv[i].rhs;
         cycle();
         chk($sformatf("tbl%0d", i), 32'(rsp_result), 32'(tv[i].exp));
      end
      req_valid = '0;
      cycle();

      // Back-pressure with all requesters active.
      for (int i = 0; i < 4; i++) begin
         req_op[i]  = 2'(i);
         req_lhs[i] = 8'(8'h11 * (i + 1));
         req_rhs[i] = 8'(8'h0F << i);
      end
      req_valid = 4'b1111;
      cycle();
      rsp_ready = 1'b0;
      repeat (5) cycle();
      rsp_ready = 1'b1;
      repeat (3) cycle();

      // Reset while full, then rotation from index 0.
      #2;
      chk("pre_rst_full", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ops", 32'(ops_done), 32'd0);
      chk("mid_rst_result", 32'(rsp_result), 32'd0);
      req_valid = '0;
      q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk($sformatf("rot%0d", i), 32'(rsp_id), 32'(rot[i]));
      end

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         req_valid = 4'($urandom_range(0, 15));
         rsp_ready = 1'($urandom_range(0, 1));
         for (int j = 0; j < 4; j++) begin
            req_op[j]  = 2'($urandom_range(0, 3));
            req_lhs[j] = 8'($urandom_range(0, 255));
            req_rhs[j] = 8'($urandom_range(0, 255));
         end
         cycle();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      cycle();

      // Saturation on the 4-bit counter instance.
      v4 = 4'b0001;
      op4[0] = 2'd3;
      lhs4[0] = 8'h0F;
      @(negedge clk);
      chk("sat_rdy", 32'(rdy4), 32'h1);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_early", 32'(ops4), 32'd2);
      chk("sat_res", 32'(res4), 32'hF0);
      chk("sat_id", 32'(id4), 32'd0);
      repeat (22) @(posedge clk);
      #1;
      v4 = '0;
      chk("sat_ops", 32'(ops4), 32'hF);
      repeat (2) @(posedge clk);
      #1;
      chk("sat_hold", 32'(ops4), 32'hF);
      chk("sat_empty", 32'(val4), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
